branch_predict_ctrl: RTL and testbench

- Dynamic branch predictor and redirect controller for the 5-stage MIPS pipeline.
- Predicts at IF using a direct-mapped BTB with a 2-bit counter per entry.
- Checks the prediction against the ID-stage branch comparator outcome (taken flag plus resolved target) and raises flush/redirect on mispredict.
- Trains the table on every resolved instruction and keeps branch/mispredict performance counters.

---
 rtl/branch_predict_ctrl_pkg.sv | 28 ++
 rtl/branch_predict_ctrl_sat.sv | 20 ++
 rtl/branch_predict_ctrl.sv | 136 +++++++++++++
 tb/tb_branch_predict_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types and PC slicing helpers for the BTB branch predictor.
// 2-bit counter codes, controller state, and the sequential-PC step.
package branch_predict_ctrl_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned PC_INC = 4;

    // Helpers work on a 64-bit view so any PC_W up to 64 can share them.
    function automatic logic [63:0] bp_index(input logic [63:0] pc, input int idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_sat.sv
// 2-bit saturating up/down counter update, purely combinational.
// Holds at ST when counting up and at SNT when counting down.
module bp_sat_counter
    import branch_predict_ctrl_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_up,
    output logic [1:0] o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_up) begin
            if (i_ctr != ST) o_ctr = i_ctr + 2'd1;
        end else begin
            if (i_ctr != SNT) o_ctr = i_ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// BTB predictor at IF, mispredict detection and redirect at ID, table training.
// Prediction and redirect are combinational; training and counters update at the clock edge.
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int PC_W  = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [PC_W-1:0] i_if_pc,
    output logic            o_pred_taken,
    output logic [PC_W-1:0] o_pred_target,
    input  logic            i_id_valid,
    input  logic            i_stall,
    input  logic [PC_W-1:0] i_id_pc,
    input  logic            i_id_is_branch,
    input  logic            i_id_taken,
    input  logic [PC_W-1:0] i_id_target,
    input  logic            i_id_pred_taken,
    input  logic [PC_W-1:0] i_id_pred_target,
    output logic            o_flush,
    output logic [PC_W-1:0] o_redirect_pc,
    output logic            o_ready,
    output logic [31:0]     o_br_cnt,
    output logic [31:0]     o_mis_cnt
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = PC_W - IDX_W - 2;

    logic              r_vld [ENTRIES];
    logic [TAG_W-1:0]  r_tag [ENTRIES];
    logic [PC_W-1:0]   r_tgt [ENTRIES];
    logic [1:0]        r_ctr [ENTRIES];

    state_e            r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic              r_ready;
    logic [31:0]       r_br_cnt;
    logic [31:0]       r_mis_cnt;

    logic [IDX_W-1:0]  w_if_idx;
    logic [TAG_W-1:0]  w_if_tag;
    logic [IDX_W-1:0]  w_id_idx;
    logic [TAG_W-1:0]  w_id_tag;
    logic              w_id_hit;
    logic              w_res;
    logic              w_mispredict;
    logic [1:0]        w_ctr_nxt;

    assign w_if_idx = IDX_W'(bp_index(64'(i_if_pc), IDX_W));
    assign w_if_tag = TAG_W'(bp_tag(64'(i_if_pc), IDX_W));
    assign w_id_idx = IDX_W'(bp_index(64'(i_id_pc), IDX_W));
    assign w_id_tag = TAG_W'(bp_tag(64'(i_id_pc), IDX_W));

    // Array reads see the pre-edge contents, so an IF/ID index collision predicts from the old entry.
    assign o_pred_taken  = (r_state == RUN) & r_vld[w_if_idx] &
                           (r_tag[w_if_idx] == w_if_tag) & r_ctr[w_if_idx][1];
    assign o_pred_target = r_tgt[w_if_idx];

    assign w_id_hit = r_vld[w_id_idx] & (r_tag[w_id_idx] == w_id_tag);
    assign w_res    = i_id_valid & ~i_stall;

    assign w_mispredict = (i_id_is_branch & (i_id_taken != i_id_pred_taken)) |
                          (i_id_is_branch & i_id_taken & (i_id_target != i_id_pred_target)) |
                          (~i_id_is_branch & i_id_pred_taken);

    assign o_flush       = w_res & w_mispredict;
    assign o_redirect_pc = !o_flush ? '0 :
                           (i_id_is_branch & i_id_taken) ? i_id_target :
                           i_id_pc + PC_W'(PC_INC);

    bp_sat_counter u_sat (
        .i_ctr (r_ctr[w_id_idx]),
        .i_up  (i_id_taken),
        .o_ctr (w_ctr_nxt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= INIT;
            r_ptr   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == IDX_W'(ENTRIES - 1)) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end
                end
                RUN: r_ready <= 1'b1;
                default: r_state <= INIT;
            endcase
        end
    end

    // Table contents need no reset: INIT sweeps every entry before predictions are enabled.
    always_ff @(posedge i_clk) begin
        if (r_state == INIT) begin
            r_vld[r_ptr] <= 1'b0;
            r_ctr[r_ptr] <= WNT;
        end else if (w_res) begin
            if (i_id_is_branch) begin
                if (w_id_hit) begin
                    r_ctr[w_id_idx] <= w_ctr_nxt;
                    if (i_id_taken) r_tgt[w_id_idx] <= i_id_target;
                end else if (i_id_taken) begin
                    r_vld[w_id_idx] <= 1'b1;
                    r_tag[w_id_idx] <= w_id_tag;
                    r_tgt[w_id_idx] <= i_id_target;
                    r_ctr[w_id_idx] <= WT;
                end
            end else if (w_id_hit) begin
                r_vld[w_id_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_br_cnt  <= '0;
            r_mis_cnt <= '0;
        end else begin
            if (w_res && i_id_is_branch && r_br_cnt != '1) r_br_cnt <= r_br_cnt + 32'd1;
            if (o_flush && r_mis_cnt != '1) r_mis_cnt <= r_mis_cnt + 32'd1;
        end
    end

    assign o_ready   = r_ready;
    assign o_br_cnt  = r_br_cnt;
    assign o_mis_cnt = r_mis_cnt;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboarded bench: a table-level predictor model queues expected outputs, a negedge monitor checks them.
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = '0, id_pc = '0, id_target = '0, id_pred_target = '0;
    logic        id_valid = 1'b0, stall = 1'b0, id_is_branch = 1'b0, id_taken = 1'b0, id_pred_taken = 1'b0;
    logic        pred_taken, flush, ready;
    logic [31:0] pred_target, redirect_pc, br_cnt, mis_cnt;

    always #5 clk = ~clk;

    branch_predict_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_if_pc(if_pc),
        .o_pred_taken(pred_taken), .o_pred_target(pred_target),
        .i_id_valid(id_valid), .i_stall(stall), .i_id_pc(id_pc),
        .i_id_is_branch(id_is_branch), .i_id_taken(id_taken), .i_id_target(id_target),
        .i_id_pred_taken(id_pred_taken), .i_id_pred_target(id_pred_target),
        .o_flush(flush), .o_redirect_pc(redirect_pc), .o_ready(ready),
        .o_br_cnt(br_cnt), .o_mis_cnt(mis_cnt)
    );

    typedef struct {
        logic        ptk;
        logic [31:0] ptgt;
        logic        fl;
        logic [31:0] rpc;
        logic        rdy;
        logic [31:0] br;
        logic [31:0] mis;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Reference model: 64-entry table addressed by word index, tag is the PC above bit 7.
    bit          m_v[64];
    int unsigned m_tag[64];
    int unsigned m_tgt[64];
    int          m_c[64];
    bit          m_ready;
    int          m_init;
    logic [31:0] m_br, m_mis;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % 64;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_v[idx_of(pc)] && m_tag[idx_of(pc)] == (pc / 256);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv(input bit rst, input logic [31:0] ifpc, input bit vld, input bit stl,
                       input logic [31:0] idpc, input bit br, input bit tk, input logic [31:0] tgt,
                       input bit ptk, input logic [31:0] ptgt);
        exp_t e;
        bit res;
        bit mis;
        int unsigned i;
        @(posedge clk);
        #1;
        rst_n = rst; if_pc = ifpc; id_valid = vld; stall = stl; id_pc = idpc;
        id_is_branch = br; id_taken = tk; id_target = tgt; id_pred_taken = ptk; id_pred_target = ptgt;
        if (!rst) begin
            m_ready = 0; m_init = 0; m_br = 0; m_mis = 0;
            for (int k = 0; k < 64; k++) m_v[k] = 0;
        end
        e.rdy  = m_ready;
        e.ptk  = m_ready && m_hit(ifpc) && m_c[idx_of(ifpc)] >= 2;
        e.ptgt = m_tgt[idx_of(ifpc)];
        res    = vld && !stl;
        mis    = (br && tk != ptk) || (br && tk && tgt != ptgt) || (!br && ptk);
        e.fl   = res && mis;
        e.rpc  = !e.fl ? 32'd0 : (br && tk) ? tgt : idpc + 32'd4;
        e.br   = m_br;
        e.mis  = m_mis;
        q.push_back(e);
        if (rst) begin
            if (res && br && m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
            if (e.fl && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
            if (m_ready && res) begin
                i = idx_of(idpc);
                if (br && m_hit(idpc)) begin
                    m_c[i] = tk ? ((m_c[i] < 3) ? m_c[i] + 1 : 3) : ((m_c[i] > 0) ? m_c[i] - 1 : 0);
                    if (tk) m_tgt[i] = tgt;
                end else if (br && tk) begin
                    m_v[i] = 1; m_tag[i] = idpc / 256; m_tgt[i] = tgt; m_c[i] = 2;
                end else if (!br && m_hit(idpc)) begin
                    m_v[i] = 0;
                end
            end
            if (!m_ready) begin
                m_init++;
                if (m_init == 64) m_ready = 1;
            end
        end
    endtask

    task automatic idle(input logic [31:0] ifpc);
        drv(1, ifpc, 0, 0, 32'd0, 0, 0, 32'd0, 0, 32'd0);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ready", {31'd0, ready}, {31'd0, e.rdy});
            chk("pred_taken", {31'd0, pred_taken}, {31'd0, e.ptk});
            if (e.ptk) chk("pred_target", pred_target, e.ptgt);
            chk("flush", {31'd0, flush}, {31'd0, e.fl});
            chk("redirect_pc", redirect_pc, e.rpc);
            chk("br_cnt", br_cnt, e.br);
            chk("mis_cnt", mis_cnt, e.mis);
        end
    end

    function automatic logic [31:0] rnd_pc();
        return 32'h0040_0000 + ($urandom_range(0, 7) * 4) + ($urandom_range(0, 1) * 32'h1000);
    endfunction

    initial begin
        logic [31:0] ipc, tgt, ptgt;
        bit ptk;
        repeat (2) drv(0, 32'h0040_0010, 0, 0, 32'd0, 0, 0, 32'd0, 0, 32'd0);
        repeat (66) idle(32'h0040_0010);

        drv(1, 32'h0040_0010, 1, 0, 32'h0040_0010, 1, 1, 32'h0040_0100, 0, 32'd0);
        idle(32'h0040_0010);
        drv(1, 32'h0040_0010, 1, 0, 32'h0040_0010, 1, 0, 32'd0, 1, 32'h0040_0100);
        idle(32'h0040_0010);
        drv(1, 32'h0040_0010, 1, 0, 32'h0040_0010, 1, 0, 32'd0, 0, 32'd0);
        idle(32'h0040_0010);

        drv(1, 32'h0040_0050, 1, 0, 32'h0040_0050, 1, 1, 32'h0040_0200, 0, 32'd0);
        idle(32'h0040_0050);
        drv(1, 32'h0040_0050, 1, 0, 32'h0040_0050, 0, 0, 32'd0, 1, 32'h0040_0200);
        idle(32'h0040_0050);

        repeat (3) drv(1, 32'h0040_0020, 1, 1, 32'h0040_0020, 1, 1, 32'h0040_0300, 0, 32'd0);
        drv(1, 32'h0040_0020, 1, 0, 32'h0040_0020, 1, 1, 32'h0040_0300, 0, 32'd0);
        idle(32'h0040_0020);

        repeat (400) begin
            ipc = rnd_pc();
            tgt = 32'h0040_0100 + $urandom_range(0, 3) * 4;
            if ($urandom_range(0, 1) == 1) begin
                ptk  = m_ready && m_hit(ipc) && m_c[idx_of(ipc)] >= 2;
                ptgt = m_tgt[idx_of(ipc)];
            end else begin
                ptk  = $urandom_range(0, 1) == 1;
                ptgt = 32'h0040_0100 + $urandom_range(0, 3) * 4;
            end
            drv(1, rnd_pc(), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, ipc,
                $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, tgt, ptk, ptgt);
        end

        repeat (2) drv(0, 32'h0040_0010, 0, 0, 32'd0, 0, 0, 32'd0, 0, 32'd0);
        repeat (66) idle(rnd_pc());
        repeat (4) idle(32'h0040_0020);

        for (int n = 0; n < 10 && q.size() > 0; n++) @(posedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
